// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and the NOP bubble word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stage-control outputs of the pipeline sequencer.
interface pipe_ctrl_if #(parameter int PERF_W = 32);
  logic stall_ld, br_taken_E, md_start_E, md_done, mem_req_M, mem_ack_M;
  logic md_go, md_err;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic [1:0] state_o;
  logic [PERF_W-1:0] stall_cnt, flush_cnt, md_cnt;

  modport master (
    output stall_ld, br_taken_E, md_start_E, md_done, mem_req_M, mem_ack_M,
    input  md_go, md_err, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input  state_o, stall_cnt, flush_cnt, md_cnt
  );

  modport slave (
    input  stall_ld, br_taken_E, md_start_E, md_done, mem_req_M, mem_ack_M,
    output md_go, md_err, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output state_o, stall_cnt, flush_cnt, md_cnt
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter with synchronous clear.
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates stall/flush causes and drives per-stage enables/flushes.
// Define PIPE_CTRL_PERF_EN to build the stall/flush/MD performance counters.
module pipe_ctrl #(
  parameter int MD_TMO = 64,
  parameter int PERF_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  pipe_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;

  // state    | meaning
  // RUN      | normal issue, RUN priorities apply
  // MD_BUSY  | MUL/DIV held in E, waiting for md_done or timeout
  // MEM_WAIT | data memory stall in M, waiting for mem_ack_M

  localparam int TMO_W = $clog2(MD_TMO);

  pipe_state_t      state, state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             mem_stall, tmo_hit;
  logic             md_go, md_err;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= (state == MD_BUSY) ? tmo_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx    = state;
    md_go       = 1'b0;
    md_err      = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    mem_stall   = bus.mem_req_M & ~bus.mem_ack_M;
    tmo_hit     = (tmo_cnt == TMO_W'(MD_TMO - 1));

    case (state)
      MD_BUSY: begin
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
        if (bus.md_done || tmo_hit) begin
          {pc_en, ifid_en, idex_en} = 3'b111;
          exmem_flush = 1'b0;
          md_err      = ~bus.md_done;
          state_nx    = RUN;
        end
      end
      default: begin
        // RUN and MEM_WAIT share one priority ladder; MEM_WAIT just re-enters rule 1
        if (mem_stall) begin
          memwb_en    = 1'b1;
          memwb_flush = 1'b1;
          state_nx    = MEM_WAIT;
        end else if (bus.md_start_E) begin
          md_go       = 1'b1;
          exmem_en    = 1'b1;
          exmem_flush = 1'b1;
          state_nx    = MD_BUSY;
        end else begin
          state_nx = RUN;
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
          if (bus.br_taken_E) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (bus.stall_ld) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
    endcase

    if (reset) begin
      state_nx    = RUN;
      md_go       = 1'b0;
      md_err      = 1'b0;
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b0;
    end
  end

  assign bus.state_o     = state;
  assign bus.md_go       = md_go;
  assign bus.md_err      = md_err;
  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt, md_cnt;

  pipe_perf_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk(clk), .clr(reset), .inc(~pc_en), .cnt(stall_cnt)
  );
  pipe_perf_cnt #(.W(PERF_W)) u_flush_cnt (
    .clk(clk), .clr(reset), .inc(ifid_flush | idex_flush), .cnt(flush_cnt)
  );
  pipe_perf_cnt #(.W(PERF_W)) u_md_cnt (
    .clk(clk), .clr(reset), .inc(state == MD_BUSY), .cnt(md_cnt)
  );

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
  assign bus.md_cnt    = md_cnt;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
  assign bus.md_cnt    = '0;
`endif

endmodule
